// File: rtl/ask_pkg.sv
// ask_pkg -- shared definitions for the ASK receive frame controller.
//   ask_state_e            : frame controller state encoding
//   ASK_SYNC_WORD_DEFAULT  : default sync pattern (MSB-first)
//   CRC8_POLY              : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
// Optional feature macro: ASK_RX_CRC8_EN adds the CHECK state.
package ask_pkg;

  localparam logic [15:0] ASK_SYNC_WORD_DEFAULT = 16'hA5C3;
  localparam logic [7:0]  CRC8_POLY             = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
`ifdef ASK_RX_CRC8_EN
    ST_PAYLOAD,
    ST_CHECK
`else
    ST_PAYLOAD
`endif
  } ask_state_e;

endpackage

// File: rtl/ask_crc8.sv
// ask_crc8 -- bitwise CRC-8 (polynomial CRC8_POLY, init 0x00), one bit per
// enabled cycle, MSB-first.  Only instantiated when ASK_RX_CRC8_EN is defined.
//   sys_clk   : clock
//   sys_rst_n : asynchronous active-low reset
//   clear_i   : force CRC register to 0x00 (wins over en_i)
//   en_i      : fold bit_i into the CRC this cycle
//   bit_i     : data bit
//   crc_o     : current CRC value
module ask_crc8
  import ask_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bit_i) ? CRC8_POLY : 8'h00);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ask_rx_frame_ctrl.sv
// ask_rx_frame_ctrl -- frames a demodulated ASK bit stream: hunts for a sync
// word, packs PAYLOAD_LEN payload bytes MSB-first into a valid/ready output
// register and flags frame start, good completion and errors (overflow,
// inter-bit timeout, CRC failure).
// Optional feature macro: ASK_RX_CRC8_EN -- appends a CRC-8 byte check (CHECK
// state) after the payload.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   enable             : receiver enable, low forces IDLE
//   bit_in, bit_valid  : demodulated bit and its one-cycle strobe
//   byte_data/valid    : payload byte output register, consumed on byte_ready
//   frame_start/done/err : one-cycle status pulses
//   busy               : high while in PAYLOAD or CHECK
module ask_rx_frame_ctrl
  import ask_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD   = ASK_SYNC_WORD_DEFAULT,
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter int unsigned BIT_TIMEOUT = 200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned     TMO_W    = $clog2(BIT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(BIT_TIMEOUT);
  localparam logic [7:0]       LAST_IDX = 8'(PAYLOAD_LEN - 1);

  ask_state_e       state_q;
  logic [14:0]      sync_q;
  logic [6:0]       data_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       byte_cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       byte_data_q;
  logic             byte_valid_q;
  logic             frame_start_q;
  logic             frame_done_q;
  logic             frame_err_q;
  logic             busy_q;

  logic [15:0]      sync_d;
  logic [7:0]       data_d;
  logic [TMO_W-1:0] tmo_d;
  logic             sync_hit;
  logic             tmo_hit;
  logic             in_check;
  logic             crc_ok;

`ifdef ASK_RX_CRC8_EN
  logic [7:0] crc_w;
  logic       crc_clr;
  logic       crc_en;

  ask_crc8 u_crc (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear_i   (crc_clr),
    .en_i      (crc_en),
    .bit_i     (bit_in),
    .crc_o     (crc_w)
  );
`endif

  always_comb begin
    sync_d   = {sync_q, bit_in};
    data_d   = {data_q, bit_in};
    sync_hit = (sync_d == SYNC_WORD);
    tmo_d    = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    tmo_hit  = (tmo_d == TMO_MAX);
`ifdef ASK_RX_CRC8_EN
    in_check = (state_q == ST_CHECK);
    crc_ok   = (data_d == crc_w);
    crc_clr  = enable && bit_valid && (state_q == ST_HUNT) && sync_hit;
    crc_en   = enable && bit_valid && (state_q == ST_PAYLOAD);
`else
    in_check = 1'b0;
    crc_ok   = 1'b0;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      sync_q        <= '0;
      data_q        <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      tmo_q         <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;

      // The output handshake runs in every state so a held byte survives an
      // abort; a load below in the same cycle overrides this clear.
      if (byte_valid_q && byte_ready) begin
        byte_valid_q <= 1'b0;
      end

      if (!enable) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_HUNT;
            sync_q  <= '0;
          end

          ST_HUNT: begin
            if (bit_valid) begin
              sync_q <= sync_d[14:0];
              if (sync_hit) begin
                state_q       <= ST_PAYLOAD;
                busy_q        <= 1'b1;
                frame_start_q <= 1'b1;
                bit_cnt_q     <= '0;
                byte_cnt_q    <= '0;
                tmo_q         <= '0;
              end
            end
          end

`ifdef ASK_RX_CRC8_EN
          ST_PAYLOAD, ST_CHECK: begin
`else
          ST_PAYLOAD: begin
`endif
            if (bit_valid) begin
              tmo_q     <= '0;
              data_q    <= data_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (in_check) begin
                  frame_done_q <= crc_ok;
                  frame_err_q  <= !crc_ok;
                  state_q      <= ST_HUNT;
                  busy_q       <= 1'b0;
                  sync_q       <= '0;
                end else if (byte_valid_q && !byte_ready) begin
                  // Overflow outranks last-byte completion: the held byte
                  // stays, the new one is dropped.
                  frame_err_q <= 1'b1;
                  state_q     <= ST_HUNT;
                  busy_q      <= 1'b0;
                  sync_q      <= '0;
                end else begin
                  byte_data_q  <= data_d;
                  byte_valid_q <= 1'b1;
                  byte_cnt_q   <= byte_cnt_q + 8'd1;
                  if (byte_cnt_q == LAST_IDX) begin
`ifdef ASK_RX_CRC8_EN
                    state_q <= ST_CHECK;
`else
                    frame_done_q <= 1'b1;
                    state_q      <= ST_HUNT;
                    busy_q       <= 1'b0;
                    sync_q       <= '0;
`endif
                  end
                end
              end
            end else if (tmo_hit) begin
              frame_err_q <= 1'b1;
              state_q     <= ST_HUNT;
              busy_q      <= 1'b0;
              sync_q      <= '0;
              tmo_q       <= '0;
            end else begin
              tmo_q <= tmo_d;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ask_rx_frame_ctrl.sv
// tb_ask_rx_frame_ctrl -- self-checking bench for ask_rx_frame_ctrl: directed
// frames plus a randomized multi-frame stream compared against a bit-stream
// level reference model.  Honours ASK_RX_CRC8_EN (CRC byte appended).
module tb_ask_rx_frame_ctrl;

  localparam logic [15:0] SYNC = 16'hA5C3;
  localparam int unsigned PLEN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  int unsigned n_start = 0;
  int unsigned n_done = 0;
  int unsigned n_errp = 0;
  logic [7:0]  got_q[$];

  bit          stream_q[$];
  logic [7:0]  pl_q[$];
  int unsigned exp_start, exp_done, exp_err;
  logic [7:0]  exp_bytes[$];

  logic        ready_rand = 1'b0;
  logic        ready_fix  = 1'b1;
  int unsigned ready_lows = 0;

  ask_rx_frame_ctrl #(
    .SYNC_WORD   (SYNC),
    .PAYLOAD_LEN (PLEN),
    .BIT_TIMEOUT (200)
  ) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .enable      (enable),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream: fixed level, or random with at most three idle cycles in a row
  // (bytes complete at least 16 cycles apart, so no overflow in random mode).
  always @(posedge clk) begin
    #1;
    if (ready_rand) begin
      if (ready_lows >= 3 || $urandom_range(0, 1) == 1) begin
        byte_ready = 1'b1;
        ready_lows = 0;
      end else begin
        byte_ready = 1'b0;
        ready_lows++;
      end
    end else begin
      byte_ready = ready_fix;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start) n_start++;
      if (frame_done)  n_done++;
      if (frame_err)   n_errp++;
      if (frame_done || frame_err)
        check_val("done_err_excl", {31'b0, frame_done & frame_err}, 32'd0);
      if (byte_valid && byte_ready) got_q.push_back(byte_data);
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int unsigned gap = $urandom_range(0, 3);
    repeat (gap) begin
      @(posedge clk); #1;
      bit_in = 1'($urandom);
    end
    @(posedge clk); #1;
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    bit_in    = 1'($urandom);
  endtask

  task automatic send_stream();
    for (int i = 0; i < stream_q.size(); i++) send_bit(stream_q[i]);
  endtask

  task automatic push_bits(input logic [15:0] v, input int unsigned w);
    for (int i = int'(w) - 1; i >= 0; i--) stream_q.push_back(v[i]);
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic add_frame(input bit corrupt);
    logic [7:0] c = 8'h00;
    push_bits(SYNC, 16);
    foreach (pl_q[i]) begin
      push_bits({8'h00, pl_q[i]}, 8);
      c = crc8_byte(c, pl_q[i]);
    end
`ifdef ASK_RX_CRC8_EN
    push_bits({8'h00, c ^ (corrupt ? 8'h5A : 8'h00)}, 8);
`endif
  endtask

  // Start a scenario from a clean HUNT: enable toggle, fresh counters.
  task automatic begin_case();
    enable = 1'b0;
    idle(2);
    enable = 1'b1;
    idle(2);
    n_start = 0; n_done = 0; n_errp = 0;
    got_q.delete();
    stream_q.delete();
  endtask

  // Reference: walk the bit stream frame by frame. A frame begins at the first
  // 16-bit window equal to SYNC lying wholly after the previous frame; a frame
  // cut off by the end of the stream ends in a timeout error.
  task automatic run_model();
    int unsigned n = stream_q.size();
    int unsigned pos = 0;
    exp_start = 0; exp_done = 0; exp_err = 0;
    exp_bytes.delete();
    while (pos + 16 <= n) begin
      int unsigned k;
      bit found = 1'b0;
      bit cut = 1'b0;
      logic [7:0] c = 8'h00;
      logic [7:0] b;
      for (k = pos + 15; k < n; k++) begin
        logic [15:0] w;
        for (int t = 0; t < 16; t++) w[15 - t] = stream_q[k - 15 + t];
        if (w == SYNC) begin found = 1'b1; break; end
      end
      if (!found) break;
      exp_start++;
      pos = k + 1;
      for (int by = 0; by < int'(PLEN); by++) begin
        if (pos + 8 > n) begin cut = 1'b1; break; end
        for (int t = 0; t < 8; t++) b[7 - t] = stream_q[pos + t];
        pos += 8;
        exp_bytes.push_back(b);
        c = crc8_byte(c, b);
      end
`ifdef ASK_RX_CRC8_EN
      if (!cut) begin
        if (pos + 8 > n) cut = 1'b1;
        else begin
          for (int t = 0; t < 8; t++) b[7 - t] = stream_q[pos + t];
          pos += 8;
          if (b == c) exp_done++; else exp_err++;
        end
      end
`else
      if (!cut) exp_done++;
`endif
      if (cut) begin exp_err++; break; end
    end
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    check_val({tag, "_count"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check_val({tag, "_byte"}, {24'b0, got_q[i]}, {24'b0, exp[i]});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    check_val("rst_byte_data", {24'b0, byte_data}, 32'h00);
    check_val("rst_byte_valid", byte_valid, 0);
    check_val("rst_frame_start", frame_start, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_frame_err", frame_err, 0);
    check_val("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle(2);

    // Nominal frame 11 22 33 44
    begin_case();
    ready_fix = 1'b1;
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    add_frame(1'b0);
    send_stream();
    idle(10);
    check_val("nom_start", n_start, 1);
    check_val("nom_done", n_done, 1);
    check_val("nom_err", n_errp, 0);
    check_val("nom_busy", busy, 0);
    check_bytes("nom", pl_q);

    // One-bit-flipped sync
    begin_case();
    push_bits(16'hA5C2, 16);
    push_bits(16'h1122, 16);
    push_bits(16'h3344, 16);
    send_stream();
    idle(10);
    check_val("badsync_start", n_start, 0);
    check_val("badsync_bytes", got_q.size(), 0);
    check_val("badsync_busy", busy, 0);

    // Overflow with byte_ready held low
    begin_case();
    ready_fix = 1'b0;
    idle(2);
    push_bits(SYNC, 16);
    push_bits(16'h0011 >> 1, 7);
    send_stream();
    check_val("ovf_pre_valid", byte_valid, 0);
    send_bit(1'b1);
    check_val("ovf_valid_lat", byte_valid, 1);
    check_val("ovf_held_data", {24'b0, byte_data}, 32'h11);
    check_val("ovf_busy_mid", busy, 1);
    stream_q.delete();
    push_bits(16'h0022, 8);
    send_stream();
    idle(2);
    check_val("ovf_err", n_errp, 1);
    check_val("ovf_done", n_done, 0);
    check_val("ovf_busy", busy, 0);
    check_val("ovf_keep_valid", byte_valid, 1);
    check_val("ovf_keep_data", {24'b0, byte_data}, 32'h11);
    ready_fix = 1'b1;
    idle(3);
    pl_q = '{8'h11};
    check_bytes("ovf", pl_q);

    // Inter-bit timeout after two payload bytes
    begin_case();
    push_bits(SYNC, 16);
    push_bits(16'h1122, 16);
    send_stream();
    idle(190);
    check_val("tmo_early_err", n_errp, 0);
    check_val("tmo_early_busy", busy, 1);
    idle(20);
    check_val("tmo_err", n_errp, 1);
    check_val("tmo_busy", busy, 0);
    check_val("tmo_done", n_done, 0);
    pl_q = '{8'h11, 8'h22};
    check_bytes("tmo", pl_q);
    begin_case();
    pl_q = '{8'h55, 8'h66, 8'h77, 8'h88};
    add_frame(1'b0);
    send_stream();
    idle(10);
    check_val("tmo_next_start", n_start, 1);
    check_val("tmo_next_done", n_done, 1);
    check_bytes("tmo_next", pl_q);

    // Reset in the middle of a sync word
    begin_case();
    push_bits(SYNC >> 6, 10);
    send_stream();
    rst_n = 1'b0;
    idle(2);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_valid", byte_valid, 0);
    rst_n = 1'b1;
    idle(2);
    stream_q.delete();
    push_bits(SYNC, 6);
    push_bits(16'h1122, 16);
    push_bits(16'h3344, 16);
    send_stream();
    idle(10);
    check_val("mid_rst_start", n_start, 0);
    check_val("mid_rst_bytes", got_q.size(), 0);

    // Enable dropped after 12 payload bits
    begin_case();
    push_bits(SYNC, 16);
    push_bits(16'h00AB, 8);
    push_bits(16'h000C, 4);
    send_stream();
    enable = 1'b0;
    idle(1);
    check_val("dis_busy", busy, 0);
    idle(250);
    check_val("dis_err", n_errp, 0);
    check_val("dis_done", n_done, 0);
    pl_q = '{8'hAB};
    check_bytes("dis", pl_q);
    begin_case();
    pl_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_frame(1'b0);
    send_stream();
    idle(10);
    check_val("reen_start", n_start, 1);
    check_val("reen_done", n_done, 1);
    check_val("reen_err", n_errp, 0);
    check_bytes("reen", pl_q);

`ifdef ASK_RX_CRC8_EN
    // CRC good / corrupted
    begin_case();
    pl_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    add_frame(1'b0);
    send_stream();
    idle(10);
    check_val("crc_ok_done", n_done, 1);
    check_val("crc_ok_err", n_errp, 0);
    check_bytes("crc_ok", pl_q);
    begin_case();
    add_frame(1'b1);
    send_stream();
    idle(10);
    check_val("crc_bad_done", n_done, 0);
    check_val("crc_bad_err", n_errp, 1);
    check_bytes("crc_bad", pl_q);
`endif

    // Randomized multi-frame stream with noise preambles and random back-pressure
    begin_case();
    ready_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int unsigned pre = $urandom_range(0, 20);
      for (int i = 0; i < int'(pre); i++) stream_q.push_back(1'($urandom));
      pl_q.delete();
      for (int i = 0; i < int'(PLEN); i++) pl_q.push_back(8'($urandom));
      add_frame($urandom_range(0, 3) == 0);
    end
    send_stream();
    idle(230);
    ready_rand = 1'b0;
    idle(3);
    run_model();
    check_val("rnd_start", n_start, exp_start);
    check_val("rnd_done", n_done, exp_done);
    check_val("rnd_err", n_errp, exp_err);
    check_bytes("rnd", exp_bytes);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ask_rx_frame_ctrl.md
ASK_RX_FRAME_CTRL -- requirements
Module: ask_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hA5C3, sync pattern searched MSB-first in the demodulated bit stream.
REQ-002 SHALL have parameter PAYLOAD_LEN, default 4, payload bytes per frame, legal range 1..255.
REQ-003 SHALL have parameter BIT_TIMEOUT, default 200, maximum sys_clk cycles allowed between bit_valid pulses inside a frame.
REQ-004 SHALL have port sys_clk  in  1  system clock, 50 MHz.
REQ-005 SHALL have port sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port enable  in  1  receiver enable; low forces IDLE.
REQ-007 SHALL have port bit_in  in  1  demodulated bit, sampled only when bit_valid=1.
REQ-008 SHALL have port bit_valid  in  1  one-cycle strobe per received symbol.
REQ-009 SHALL have port byte_data  out  8  payload byte.
REQ-010 SHALL have port byte_valid  out  1  byte_data holds an unconsumed byte.
REQ-011 SHALL have port byte_ready  in  1  downstream accepts byte when byte_valid && byte_ready.
REQ-012 SHALL have port frame_start  out  1  one-cycle pulse on sync match.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse on good frame completion.
REQ-014 SHALL have port frame_err  out  1  one-cycle pulse on overflow, timeout or CRC failure.
REQ-015 SHALL have port busy  out  1  high in PAYLOAD and CHECK states.

Function
REQ-016 SHALL implement states IDLE, HUNT, PAYLOAD, CHECK (CHECK only per REQ-030).
REQ-017 IDLE -> HUNT when enable=1; any state -> IDLE on the cycle after enable=0, aborting the frame without frame_err; a pending output byte is retained until accepted.
REQ-018 HUNT: 16-bit shift register shifts bit_in in at LSB on each bit_valid; match against SYNC_WORD evaluated on the updated value; match -> PAYLOAD, frame_start pulse next cycle, bit counter and byte counter cleared.
REQ-019 Shift register SHALL be cleared on entry to HUNT, so a sync match requires 16 fresh bits.
REQ-020 PAYLOAD: bits packed MSB-first; on 8th bit the byte is loaded into byte_data and byte_valid set on the next cycle (latency 1 cycle from completing bit_valid).
REQ-021 Output register: byte_valid clears on byte_valid && byte_ready; a new byte arriving in the same cycle as acceptance is loaded with no loss.
REQ-022 Overflow: new byte completes while byte_valid=1 and byte_ready=0 -> new byte dropped, frame_err pulse, -> HUNT; held byte kept.
REQ-023 Timeout counter, saturating, cleared by each bit_valid, counts in PAYLOAD/CHECK; reaching BIT_TIMEOUT -> frame_err pulse, -> HUNT.
REQ-024 After PAYLOAD_LEN bytes: -> CHECK if compiled in, else frame_done pulse and -> HUNT.
REQ-025 frame_done and frame_err SHALL never assert in the same cycle; overflow takes priority over completion of the last byte.

Reset
REQ-026 On sys_rst_n low all outputs SHALL be 0, byte_data 8'h00, state IDLE, all counters and shift register 0.
REQ-027 Reset deassertion mid-stream SHALL not produce frame_start until a full fresh SYNC_WORD is received.

Configuration
REQ-028 Macro ASK_RX_CRC8_EN selects payload CRC checking.
REQ-029 Defined: CRC-8, polynomial 0x07, init 0x00, updated per payload bit MSB-first, reset at sync match.
REQ-030 Defined: CHECK receives 8 more bits; equal to computed CRC -> frame_done, else frame_err; both -> HUNT; CRC byte never output on byte_data.
REQ-031 Undefined: no CRC logic, no CHECK state, frame_done immediately after the last payload byte is loaded.

Structure
REQ-032 Shared package ask_pkg SHALL hold the state enumeration, the SYNC_WORD default and CRC8_POLY constant.
REQ-033 CRC SHALL be a sub-module ask_crc8 (bitwise, enable/clear/bit inputs), instantiated only under ASK_RX_CRC8_EN.

Verification
REQ-034 Sync A5C3 then bytes 11 22 33 44, byte_ready=1 -> frame_start once, bytes 11,22,33,44 in order, frame_done once.
REQ-035 Sync with one bit flipped (A5C2) then payload -> no frame_start, no byte_valid.
REQ-036 byte_ready=0 throughout valid frame -> byte 11 held, frame_err on 2nd byte completion, state HUNT.
REQ-037 Bits stop after 2 payload bytes for 200 cycles -> frame_err pulse, busy=0, next frame received normally.
REQ-038 With ASK_RX_CRC8_EN, payload 01 02 03 04 with correct CRC -> frame_done; corrupted CRC -> frame_err.
REQ-039 enable dropped after 12 payload bits -> IDLE next cycle, no frame_done/frame_err; re-enable then full frame -> normal reception.
